multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle LEGv8 control unit. A Moore FSM sequences the shared datapath resources: PC, instruction register, register file, the sign-extend unit feeding the ALU's B operand, ALU, and unified memory. Instructions take 3–5 cycles instead of one. It replaces the single-cycle decoder when the processor runs in multicycle mode. Supported instructions are LDUR, STUR, CBZ, ADD, SUB, AND and ORR.

## Interface
- MEM_WAIT, default 0, number of extra wait cycles held in every memory-access state (FETCH, MEMREAD, MEMWRITE); range 0–7.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- op  in  11  instruction bits [31:21] taken from the instruction register.
- zero  in  1  ALU zero flag (combinational, current cycle).
- PCWrite  out  1  PC register load enable.
- IRWrite  out  1  loads the instruction register and the OldPC register (OldPC ← PC).
- RegWrite  out  1  register-file write enable.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemtoReg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- Reg2Loc  out  1  read-port-2 select: 0 = instr[20:16], 1 = instr[4:0].
- PCSrc  out  1  PC next select: 0 = ALU result, 1 = ALUOut.
- ALUSrcA  out  2  ALU A operand: 00 = PC, 01 = A register, 10 = OldPC.
- ALUSrcB  out  2  ALU B operand: 00 = B register, 01 = 4, 10 = signext, 11 = signext<<2.
- ALUControl  out  4  ALU operation: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B.
- state  out  4  current state encoding, for debug and the bench.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8.
  - 9–15 are unreachable; if entered, the next state is FETCH.
- Opcode classes:
  - LDUR = 11111000010.
  - STUR = 11111000000.
  - CBZ when op[10:3] = 10110100.
  - ADD = 10001011000, SUB = 11001011000, AND = 10001010000, ORR = 10101010000.
  - Anything else is unsupported and is treated as a NOP.
- FETCH:
  - Outputs: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUControl=0010, PCSrc=0.
  - IRWrite=1 and PCWrite=1 only in the last wait cycle.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=10, ALUSrcB=11, ALUControl=0010, so ALUOut ← OldPC + imm<<2.
  - Reg2Loc=1 for STUR and CBZ, else 0.
  - Next state: MEMADR for LDUR/STUR, EXECUTE for R-type, BRANCH for CBZ, FETCH for unsupported.
- MEMADR: ALUSrcA=01, ALUSrcB=10, ADD, Reg2Loc=1 for STUR. Next state: MEMREAD for LDUR, MEMWRITE for STUR.
- MEMREAD: IorD=1, MemRead=1 for all wait cycles. Next state: MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Next state: FETCH.
- MEMWRITE: IorD=1, Reg2Loc=1. MemWrite=1 only in the last wait cycle, so exactly one write occurs. Next state: FETCH.
- EXECUTE:
  - ALUSrcA=01, ALUSrcB=00.
  - ALUControl from op: ADD→0010, SUB→0110, AND→0000, ORR→0001.
  - Next state: ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. Next state: FETCH.
- BRANCH:
  - Reg2Loc=1, ALUSrcB=00, ALUControl=0111, PCSrc=1.
  - PCWrite = zero, the only Mealy term.
  - Next state: FETCH.
- Defaults: every output not listed for a state is 0.

## Timing
- Wait counter:
  - 3 bits, cleared on every state change.
  - A memory state exits when the count equals MEM_WAIT; otherwise it stays and the count increments.
- Latency with MEM_WAIT=0:
  - CBZ 3 cycles, STUR 4, R-type 4, LDUR 5, unsupported 2.
  - Each memory state adds MEM_WAIT cycles.
- Reset:
  - While reset=1: all write enables and strobes (PCWrite, IRWrite, RegWrite, MemRead, MemWrite) are forced to 0; the other outputs show FETCH values.
  - After the reset edge: state=0, wait counter=0.
  - Reset asserted mid-instruction aborts it on the next edge, with no partial write. For example, reset during MEMWRITE with MEM_WAIT>0 before the last wait cycle must produce no MemWrite pulse.
- op is sampled only in DECODE, EXECUTE, MEMADR and BRANCH. It is stable there because IRWrite=0 outside FETCH.

## Test plan
- Reset, then deassert; op=LDUR (11111000010), MEM_WAIT=0 -> state 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; MemRead=1 in states 0 and 3.
- op=STUR, MEM_WAIT=2 -> FETCH held 3 cycles with IRWrite a single pulse; MEMWRITE held 3 cycles with MemWrite high only in the 3rd; total 8 cycles.
- op=10110100xxx: zero=1 -> PCWrite=1 with PCSrc=1 in BRANCH; zero=0 -> PCWrite=0; 3 cycles each.
- op=SUB (11001011000), then AND, ORR, ADD -> EXECUTE ALUControl = 0110, 0000, 0001, 0010; ALUWB RegWrite=1.
- op=01110100000 (unsupported) -> 0,1,0; RegWrite, MemWrite and PCWrite (after FETCH) stay 0.
- Reset asserted in MEMREAD of LDUR (MEM_WAIT=3) -> next state 0; no RegWrite pulse at any point.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Moore FSM that sequences the shared multicycle LEGv8 datapath through
// FETCH/DECODE/... one state per cycle. Memory states (FETCH, MEMREAD,
// MEMWRITE) are held for MEM_WAIT extra cycles. The state's one-shot effects
// (IR/PC load, memory write) fire only in the final held cycle.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   op[10:0]           : instruction bits [31:21] from the IR
//   zero               : ALU zero flag (drives PCWrite in BRANCH)
//   PCWrite .. PCSrc   : datapath enables and selects
//   ALUSrcA, ALUSrcB   : ALU operand selects
//   ALUControl         : ALU operation
//   state              : current state encoding (debug)
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        PCSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    logic [3:0] state_q, state_d;
    logic [2:0] wcnt_q;
    logic       last;

    logic is_ldur, is_stur, is_cbz, is_add, is_sub, is_and, is_orr, is_r;

    assign is_ldur = (op == 11'b11111000010);
    assign is_stur = (op == 11'b11111000000);
    assign is_cbz  = (op[10:3] == 8'b10110100);
    assign is_add  = (op == 11'b10001011000);
    assign is_sub  = (op == 11'b11001011000);
    assign is_and  = (op == 11'b10001010000);
    assign is_orr  = (op == 11'b10101010000);
    assign is_r    = is_add | is_sub | is_and | is_orr;

    // Final held cycle of a memory state; non-memory states ignore it.
    assign last  = (wcnt_q == WAIT_LAST);
    assign state = state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = last ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_ldur | is_stur) state_d = S_MEMADR;
                else if (is_r)         state_d = S_EXECUTE;
                else if (is_cbz)       state_d = S_BRANCH;
                else                   state_d = S_FETCH;
            end
            S_MEMADR: begin
                if (is_ldur)      state_d = S_MEMREAD;
                else if (is_stur) state_d = S_MEMWRITE;
                else              state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = last ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = last ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Counter runs only while a state holds; any transition restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= (state_d == state_q) ? wcnt_q + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        MemtoReg   = 1'b0;
        Reg2Loc    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        if (reset) begin
            // Strobes stay low; selects park at FETCH values.
            ALUSrcB    = 2'b01;
            ALUControl = 4'b0010;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = 4'b0010;
                    IRWrite    = last;
                    PCWrite    = last;
                end
                S_DECODE: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b11;
                    ALUControl = 4'b0010;
                    Reg2Loc    = is_stur | is_cbz;
                end
                S_MEMADR: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    ALUControl = 4'b0010;
                    Reg2Loc    = is_stur;
                end
                S_MEMREAD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD     = 1'b1;
                    Reg2Loc  = 1'b1;
                    MemWrite = last;
                end
                S_EXECUTE: begin
                    ALUSrcA = 2'b01;
                    if (is_sub)      ALUControl = 4'b0110;
                    else if (is_and) ALUControl = 4'b0000;
                    else if (is_orr) ALUControl = 4'b0001;
                    else             ALUControl = 4'b0010;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    Reg2Loc    = 1'b1;
                    ALUControl = 4'b0111;
                    PCSrc      = 1'b1;
                    PCWrite    = zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three instances with MEM_WAIT = 0, 2, 3.
// A phase-list reference model expands each instruction into its expected
// cycle sequence and per-cycle outputs.
module tb_multicycle_ctrl;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mr, mw, iord, m2r, r2l, pcsrc;
        logic [1:0] asa, asb;
        logic [3:0] alu;
    } obs_t;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_WB = 4,
                   P_MW = 5, P_E = 6, P_AW = 7, P_B = 8;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_NOP  = 11'b01110100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       rst, zero, pcw, irw, rw, mr, mw, iord, m2r, r2l, pcsrc;
    logic [NDUT-1:0][10:0] opv;
    logic [NDUT-1:0][1:0]  asa, asb;
    logic [NDUT-1:0][3:0]  alu, st;

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        multicycle_ctrl #(.MEM_WAIT(g == 0 ? 0 : g + 1)) u_dut (
            .clk(clk), .reset(rst[g]), .op(opv[g]), .zero(zero[g]),
            .PCWrite(pcw[g]), .IRWrite(irw[g]), .RegWrite(rw[g]),
            .MemRead(mr[g]), .MemWrite(mw[g]), .IorD(iord[g]),
            .MemtoReg(m2r[g]), .Reg2Loc(r2l[g]), .PCSrc(pcsrc[g]),
            .ALUSrcA(asa[g]), .ALUSrcB(asb[g]), .ALUControl(alu[g]),
            .state(st[g])
        );
    end

    function automatic int mwait(int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    function automatic obs_t sample(int d);
        obs_t o;
        o = '{st[d], pcw[d], irw[d], rw[d], mr[d], mw[d], iord[d], m2r[d],
              r2l[d], pcsrc[d], asa[d], asb[d], alu[d]};
        return o;
    endfunction

    function automatic bit is_r(logic [10:0] o);
        return o == OP_ADD || o == OP_SUB || o == OP_AND || o == OP_ORR;
    endfunction

    function automatic bit is_cbz(logic [10:0] o);
        return o[10:3] == 8'b10110100;
    endfunction

    // Phase list of one instruction, straight from the instruction classes.
    function automatic void phases(logic [10:0] o, ref int q[$]);
        q = {P_F, P_D};
        if (o == OP_LDUR)      q = {q, P_MA, P_MR, P_WB};
        else if (o == OP_STUR) q = {q, P_MA, P_MW};
        else if (is_r(o))      q = {q, P_E, P_AW};
        else if (is_cbz(o))    q = {q, P_B};
    endfunction

    function automatic obs_t expect_cyc(int ph, bit last, logic [10:0] o, logic z);
        obs_t e;
        e = '0;
        e.st = 4'(ph);
        case (ph)
            P_F:  begin e.mr = 1; e.asb = 2'b01; e.alu = 4'b0010; e.irw = last; e.pcw = last; end
            P_D:  begin e.asa = 2'b10; e.asb = 2'b11; e.alu = 4'b0010;
                        e.r2l = (o == OP_STUR) || is_cbz(o); end
            P_MA: begin e.asa = 2'b01; e.asb = 2'b10; e.alu = 4'b0010; e.r2l = (o == OP_STUR); end
            P_MR: begin e.iord = 1; e.mr = 1; end
            P_WB: begin e.rw = 1; e.m2r = 1; end
            P_MW: begin e.iord = 1; e.r2l = 1; e.mw = last; end
            P_E:  begin e.asa = 2'b01;
                        e.alu = (o == OP_SUB) ? 4'b0110 : (o == OP_AND) ? 4'b0000 :
                                (o == OP_ORR) ? 4'b0001 : 4'b0010; end
            P_AW: e.rw = 1;
            P_B:  begin e.r2l = 1; e.alu = 4'b0111; e.pcsrc = 1; e.pcw = z; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(int d, obs_t got, obs_t exp, string tag);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, got, exp);
        end
    endtask

    // Reset-time outputs: FETCH selects, strobes low; state not compared.
    task automatic check_reset_outs(int d, string tag);
        obs_t g, e;
        g = sample(d);
        g.st = 4'd0;
        e = '0;
        e.asb = 2'b01;
        e.alu = 4'b0010;
        check(d, g, e, tag);
    endtask

    task automatic check_state0(int d, string tag);
        n_assert++;
        assert (st[d] === 4'd0) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed state %0d expected 0", tag, d, st[d]);
        end
    endtask

    // Called at a negedge+1 with the DUT in the current cycle.
    task automatic do_reset(int d);
        rst[d] = 1'b1;
        #1;
        check_reset_outs(d, "reset_outs");
        @(negedge clk);
        #1;
        check_state0(d, "reset_state");
        rst[d] = 1'b0;
        #1;
    endtask

    // Runs one instruction; abort_at >= 0 asserts reset at that cycle index.
    task automatic run_instr(int d, logic [10:0] o, logic z, int abort_at, string tag);
        int q[$];
        int idx, len;
        phases(o, q);
        opv[d]  = o;
        zero[d] = z;
        #1;
        idx = 0;
        foreach (q[i]) begin
            len = (q[i] == P_F || q[i] == P_MR || q[i] == P_MW) ? mwait(d) + 1 : 1;
            for (int k = 0; k < len; k++) begin
                if (idx == abort_at) begin
                    rst[d] = 1'b1;
                    #1;
                    check_reset_outs(d, {tag, "_abort"});
                    @(negedge clk);
                    #1;
                    check_state0(d, {tag, "_abort_state"});
                    rst[d] = 1'b0;
                    #1;
                    return;
                end
                check(d, sample(d), expect_cyc(q[i], k == len - 1, o, z), tag);
                @(negedge clk);
                #1;
                idx++;
            end
        end
    endtask

    function automatic logic [10:0] rand_op();
        logic [10:0] r;
        r = 11'($urandom);
        case ($urandom_range(0, 7))
            0: return OP_LDUR;
            1: return OP_STUR;
            2: return {8'b10110100, r[2:0]};
            3: return OP_ADD;
            4: return OP_SUB;
            5: return OP_AND;
            6: return OP_ORR;
            default: return r;
        endcase
    endfunction

    task automatic run_random(int d, int n);
        for (int i = 0; i < n; i++)
            run_instr(d, rand_op(), 1'($urandom), -1, "random");
    endtask

    initial begin
        rst  = '1;
        zero = '0;
        for (int d = 0; d < NDUT; d++) opv[d] = OP_NOP;
        @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_reset_outs(d, "init_reset_outs");
            check_state0(d, "init_reset_state");
        end
        rst = '0;
        #1;

        // MEM_WAIT = 0
        run_instr(0, OP_LDUR, 1'b0, -1, "ldur");
        run_instr(0, {8'b10110100, 3'b101}, 1'b1, -1, "cbz_taken");
        run_instr(0, {8'b10110100, 3'b010}, 1'b0, -1, "cbz_not_taken");
        run_instr(0, OP_SUB, 1'b0, -1, "sub");
        run_instr(0, OP_AND, 1'b1, -1, "and");
        run_instr(0, OP_ORR, 1'b0, -1, "orr");
        run_instr(0, OP_ADD, 1'b0, -1, "add");
        run_instr(0, OP_NOP, 1'b1, -1, "nop");
        run_instr(0, OP_STUR, 1'b0, -1, "stur");
        run_random(0, 30);

        // MEM_WAIT = 2
        do_reset(1);
        run_instr(1, OP_STUR, 1'b0, -1, "stur_w2");
        run_instr(1, OP_LDUR, 1'b0, -1, "ldur_w2");
        run_instr(1, OP_STUR, 1'b0, 6, "stur_w2");   // mid MEMWRITE, before write
        run_instr(1, OP_STUR, 1'b0, -1, "stur_w2_after");
        run_random(1, 20);

        // MEM_WAIT = 3
        do_reset(2);
        run_instr(2, OP_LDUR, 1'b0, 8, "ldur_w3");   // mid MEMREAD
        run_instr(2, OP_LDUR, 1'b0, -1, "ldur_w3_after");
        run_random(2, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
